// File: rtl/cg_rv_decode_issue.sv
// cg_rv_decode_issue: single-entry RV32I/RV64I decode stage issuing behind a register scoreboard
module cg_rv_decode_issue #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_rd_we,
  output logic            o_illegal,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd
);
  typedef enum logic {EMPTY, HELD} state_t;
  state_t state, state_nxt;
  logic [31:0] pend, pend_nxt, wb_clr, busy;
  logic uses_rs1, uses_rs2, hazard, accept, issue;
  logic is_lui, is_auipc, is_jal, is_jalr, is_load, is_opimm, is_sys, is_br, is_st, is_op, is_misc;
  logic d_legal, d_rs1, d_rs2, d_we;
  logic [2:0] d_typ;
  logic [31:0] d_imm32;
  logic [6:0] op;
  always_comb begin
    op = i_instr[6:0];
    is_lui = op == 7'b0110111;
    is_auipc = op == 7'b0010111;
    is_jal = op == 7'b1101111;
    is_jalr = op == 7'b1100111;
    is_load = op == 7'b0000011;
    is_opimm = op == 7'b0010011;
    is_sys = op == 7'b1110011;
    is_br = op == 7'b1100011;
    is_st = op == 7'b0100011;
    is_op = op == 7'b0110011;
    is_misc = op == 7'b0001111;
    d_legal = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_sys | is_br | is_st | is_op | is_misc;
    d_typ = (is_lui | is_auipc) ? 3'd4 :
            is_jal ? 3'd5 :
            (is_jalr | is_load | is_opimm | is_sys | is_misc) ? 3'd1 :
            is_br ? 3'd3 :
            is_st ? 3'd2 : 3'd0;
    d_imm32 = d_typ == 3'd1 ? {{20{i_instr[31]}}, i_instr[31:20]} :
              d_typ == 3'd2 ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
              d_typ == 3'd3 ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
              d_typ == 3'd4 ? {i_instr[31:12], 12'b0} :
              d_typ == 3'd5 ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
              32'b0;
    d_rs1 = d_legal & ~(is_lui | is_auipc | is_jal);
    d_rs2 = is_br | is_st | is_op;
    d_we = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op | is_sys) & (i_instr[11:7] != 5'd0);
  end
  always_comb begin
    wb_clr = i_wb_valid ? (32'b1 << i_wb_rd) : 32'b0;
    busy = pend & ~wb_clr;
    hazard = (uses_rs1 & busy[o_rs1]) | (uses_rs2 & busy[o_rs2]) | (o_rd_we & busy[o_rd]);
    o_valid = (state == HELD) & ~hazard & ~i_flush & ~i_rst;
    o_ready = ~i_rst & ~i_flush & ((state == EMPTY) | (o_valid & i_ready));
    accept = i_valid & o_ready;
    issue = o_valid & i_ready;
    state_nxt = i_flush ? EMPTY : accept ? HELD : issue ? EMPTY : state;
    pend_nxt = ((pend & ~wb_clr) | ((issue & o_rd_we) ? (32'b1 << o_rd) : 32'b0)) & ~32'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= EMPTY;
      pend <= '0;
    end else begin
      state <= state_nxt;
      pend <= pend_nxt;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc <= '0;
      o_opcode <= '0;
      o_rd <= '0;
      o_rs1 <= '0;
      o_rs2 <= '0;
      o_funct3 <= '0;
      o_funct7 <= '0;
      o_imm <= '0;
      o_imm_type <= '0;
      o_rd_we <= 1'b0;
      o_illegal <= 1'b0;
      uses_rs1 <= 1'b0;
      uses_rs2 <= 1'b0;
    end else if (accept) begin
      o_pc <= i_pc;
      o_opcode <= i_instr[6:0];
      o_rd <= i_instr[11:7];
      o_rs1 <= i_instr[19:15];
      o_rs2 <= i_instr[24:20];
      o_funct3 <= i_instr[14:12];
      o_funct7 <= i_instr[31:25];
      o_imm <= XLEN'($signed(d_imm32));
      o_imm_type <= d_typ;
      o_rd_we <= d_we;
      o_illegal <= ~d_legal;
      uses_rs1 <= d_rs1;
      uses_rs2 <= d_rs2;
    end
  end
endmodule

// File: tb/tb_cg_rv_decode_issue.sv
// tb_cg_rv_decode_issue: directed scoreboard bench for the decode/issue stage
module tb_cg_rv_decode_issue;
  logic clk = 1'b0;
  logic i_rst, i_flush, i_valid, i_ready, i_wb_valid;
  logic [31:0] i_instr, i_pc;
  logic [4:0] i_wb_rd;
  logic o_ready, o_valid, o_rd_we, o_illegal;
  logic [31:0] o_pc, o_imm;
  logic [6:0] o_opcode, o_funct7;
  logic [4:0] o_rd, o_rs1, o_rs2;
  logic [2:0] o_funct3, o_imm_type;
  logic r64, v64, we64, ill64;
  logic [63:0] pc64, imm64;
  logic [6:0] op64, f7_64;
  logic [4:0] rd64, rs1_64, rs2_64;
  logic [2:0] f3_64, typ64;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0] typ;
    logic we;
    logic ill;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  cg_rv_decode_issue #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_opcode(o_opcode), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct3(o_funct3),
    .o_funct7(o_funct7), .o_imm(o_imm), .o_imm_type(o_imm_type), .o_rd_we(o_rd_we),
    .o_illegal(o_illegal), .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd)
  );
  cg_rv_decode_issue #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(r64),
    .i_instr(i_instr), .i_pc({32'h0, i_pc}), .o_valid(v64), .i_ready(i_ready), .o_pc(pc64),
    .o_opcode(op64), .o_rd(rd64), .o_rs1(rs1_64), .o_rs2(rs2_64), .o_funct3(f3_64),
    .o_funct7(f7_64), .o_imm(imm64), .o_imm_type(typ64), .o_rd_we(we64),
    .o_illegal(ill64), .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic neg;
    @(negedge clk);
  endtask
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    i_valid = 1'b1;
    i_instr = instr;
    i_pc = pc;
  endtask
  task automatic expect_issue(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                              input logic [2:0] typ, input logic we, input logic ill);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.imm = imm;
    e.typ = typ;
    e.we = we;
    e.ill = ill;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (o_valid && i_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL issue: unexpected pc %h instr opcode %h", o_pc, o_opcode);
      end else begin
        e = q.pop_front();
        if ({o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_funct3, o_funct7, o_imm, o_imm_type, o_rd_we, o_illegal} !==
            {e.pc, e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[31:25],
             e.imm, e.typ, e.we, e.ill}) begin
          n_err++;
          $display("FAIL issue pc %h: got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h typ=%0d we=%b ill=%b expected instr=%h imm=%h typ=%0d we=%b ill=%b",
                   o_pc, o_opcode, o_rd, o_rs1, o_rs2, o_funct3, o_funct7, o_imm, o_imm_type, o_rd_we, o_illegal,
                   e.instr, e.imm, e.typ, e.we, e.ill);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    i_rst = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_wb_valid = 1'b0;
    i_wb_rd = 5'd0;
    i_instr = 32'h0;
    i_pc = 32'h0;
    repeat (2) cyc();
    neg();
    chk("reset o_valid", 64'(o_valid), 64'd0);
    chk("reset o_ready", 64'(o_ready), 64'd0);
    chk("reset o_rd", 64'(o_rd), 64'd0);
    chk("reset o_imm", 64'(o_imm), 64'd0);
    chk("reset o_pc", 64'(o_pc), 64'd0);
    cyc();
    i_rst = 1'b0;
    send(32'h00500093, 32'h100);
    expect_issue(32'h100, 32'h00500093, 32'h5, 3'd1, 1'b1, 1'b0);
    neg();
    chk("empty o_ready", 64'(o_ready), 64'd1);
    cyc();
    i_valid = 1'b0;
    neg();
    chk("addi valid next cycle", 64'(o_valid), 64'd1);
    cyc();
    send(32'h00108133, 32'h104);
    expect_issue(32'h104, 32'h00108133, 32'h0, 3'd0, 1'b1, 1'b0);
    neg();
    chk("pend x1 after addi", 64'(dut.pend[1]), 64'd1);
    cyc();
    i_valid = 1'b0;
    neg();
    chk("add stalled on x1", 64'(o_valid), 64'd0);
    cyc();
    i_wb_valid = 1'b1;
    i_wb_rd = 5'd1;
    neg();
    chk("add wb bypass", 64'(o_valid), 64'd1);
    cyc();
    i_wb_valid = 1'b0;
    send(32'hFE000EE3, 32'h108);
    expect_issue(32'h108, 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b0);
    neg();
    chk("pend after add", 64'(dut.pend), 64'h4);
    cyc();
    send(32'h800002B7, 32'h10C);
    expect_issue(32'h10C, 32'h800002B7, 32'h80000000, 3'd4, 1'b1, 1'b0);
    neg();
    chk("issue+accept o_ready", 64'(o_ready), 64'd1);
    cyc();
    i_valid = 1'b0;
    neg();
    chk("lui imm xlen64", imm64, 64'hFFFFFFFF80000000);
    cyc();
    send(32'h00000000, 32'h110);
    expect_issue(32'h110, 32'h00000000, 32'h0, 3'd0, 1'b0, 1'b1);
    neg();
    cyc();
    i_valid = 1'b0;
    neg();
    chk("illegal issues", 64'(o_valid), 64'd1);
    cyc();
    i_ready = 1'b0;
    send(32'h00500093, 32'h114);
    expect_issue(32'h114, 32'h00500093, 32'h5, 3'd1, 1'b1, 1'b0);
    neg();
    chk("pend after illegal", 64'(dut.pend), 64'h24);
    cyc();
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      neg();
      chk("stall o_ready", 64'(o_ready), 64'd0);
      chk("stall o_valid", 64'(o_valid), 64'd1);
      chk("stall o_imm", 64'(o_imm), 64'd5);
      chk("stall o_pc", 64'(o_pc), 64'h114);
      cyc();
    end
    i_ready = 1'b1;
    send(32'h00108133, 32'h118);
    neg();
    chk("backpressure release o_ready", 64'(o_ready), 64'd1);
    cyc();
    i_valid = 1'b0;
    neg();
    chk("add stalled before flush", 64'(o_valid), 64'd0);
    cyc();
    i_flush = 1'b1;
    i_wb_valid = 1'b1;
    i_wb_rd = 5'd2;
    neg();
    chk("flush o_valid", 64'(o_valid), 64'd0);
    chk("flush o_ready", 64'(o_ready), 64'd0);
    cyc();
    i_flush = 1'b0;
    i_wb_valid = 1'b0;
    neg();
    chk("post flush o_valid", 64'(o_valid), 64'd0);
    chk("post flush empty", 64'(o_ready), 64'd1);
    chk("pend after flush+wb", 64'(dut.pend), 64'h22);
    send(32'h00108133, 32'h11C);
    cyc();
    i_valid = 1'b0;
    i_rst = 1'b1;
    neg();
    chk("rst o_valid", 64'(o_valid), 64'd0);
    chk("rst o_ready", 64'(o_ready), 64'd0);
    cyc();
    i_rst = 1'b0;
    send(32'hFE112E23, 32'h200);
    expect_issue(32'h200, 32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b0);
    neg();
    chk("pend after reset", 64'(dut.pend), 64'h0);
    chk("o_valid after reset", 64'(o_valid), 64'd0);
    chk("o_rd after reset", 64'(o_rd), 64'd0);
    cyc();
    send(32'h008000EF, 32'h204);
    expect_issue(32'h204, 32'h008000EF, 32'h8, 3'd5, 1'b1, 1'b0);
    neg();
    cyc();
    i_valid = 1'b0;
    neg();
    cyc();
    neg();
    chk("pend after jal", 64'(dut.pend), 64'h2);
    repeat (2) cyc();
    neg();
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cg_rv_decode_issue.md
Name: cg_rv_decode_issue

Overview:
- Single-entry RV32I/RV64I decode-and-issue stage between fetch and execute.
- Accepts raw 32-bit instructions over a valid/ready handshake and extracts opcode, rd, rs1, rs2, funct3, funct7 and the sign-extended immediate.
- Holds each instruction until a 32-entry register scoreboard shows no RAW/WAW hazard, then issues it downstream.
- Writeback clears scoreboard entries.

Parameters:
XLEN, 32, datapath width for PC and immediate; legal values 32 or 64.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_flush  in  1  discard held instruction
i_valid  in  1  fetch instruction valid
o_ready  out  1  stage can accept
i_instr  in  32  instruction word
i_pc  in  XLEN  instruction PC
o_valid  out  1  decoded instruction issuing
i_ready  in  1  execute accepts
o_pc  out  XLEN  held PC
o_opcode  out  7  instr[6:0]
o_rd  out  5  instr[11:7]
o_rs1  out  5  instr[19:15]
o_rs2  out  5  instr[24:20]
o_funct3  out  3  instr[14:12]
o_funct7  out  7  instr[31:25]
o_imm  out  XLEN  sign-extended immediate
o_imm_type  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J
o_rd_we  out  1  writes rd (rd!=0)
o_illegal  out  1  unsupported encoding
i_wb_valid  in  1  writeback completes
i_wb_rd  in  5  writeback register

Behaviour:
- State: EMPTY / HELD, plus pend[31:0] (bit 0 hard-wired 0).
- Reset (i_rst=1 at a clock edge): EMPTY, pend=0, all decoded output registers = 0. o_valid=0 and o_ready=0 while i_rst is high.
- Accept: i_valid && o_ready && !i_flush. All decoded fields are registered and the state becomes HELD next cycle. Minimum latency is accept in cycle N, o_valid in cycle N+1.
- o_ready = !i_rst && !i_flush && (EMPTY || (o_valid && i_ready)). Back-to-back accept and issue sustain 1 instruction/cycle.
- Opcode decode and immediate type:
  - LUI 0110111 and AUIPC 0010111: U.
  - JAL 1101111: J.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, SYSTEM 1110011: I.
  - BRANCH 1100011: B.
  - STORE 0100011: S.
  - OP 0110011: R.
  - MISC-MEM 0001111: I.
- Illegal: any other opcode. Forces o_illegal=1, rd_we=0, uses_rs1=uses_rs2=0.
- Immediate formats (sign bit instr[31], extended to XLEN):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R/illegal: 0.
- Register usage flags:
  - uses_rs1: every legal opcode except LUI, AUIPC, JAL.
  - uses_rs2: BRANCH, STORE, OP.
  - rd_we: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM, and only when rd!=0.
- Hazard check:
  - busy(r) = pend[r] && !(i_wb_valid && i_wb_rd==r). Same-cycle writeback bypasses the scoreboard.
  - hazard = (uses_rs1 && busy(rs1)) | (uses_rs2 && busy(rs2)) | (rd_we && busy(rd)).
- o_valid = HELD && !hazard && !i_flush.
- Issue = o_valid && i_ready. Next state is HELD if a new instruction is accepted in the same cycle, otherwise EMPTY.
- Scoreboard update:
  - Issue with rd_we sets pend[rd].
  - i_wb_valid with i_wb_rd!=0 clears pend[i_wb_rd].
  - Same register set and cleared in the same cycle: set wins.
  - Writeback to a register that is not pending: no effect.
- While HELD and not issuing, all o_* data outputs stay stable.
- i_flush:
  - Next state EMPTY; the held instruction is dropped and no issue happens that cycle.
  - pend is not modified; in-flight writers still write back.
  - Input is not accepted during a flush cycle.
- i_flush and i_wb_valid in the same cycle: the writeback clear still applies.
- XLEN=64: identical except o_pc/o_imm widen with sign extension from instr[31].

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) at PC 0x100 → next cycle o_valid=1, rd=1, rs1=0, imm=5, imm_type=1, rd_we=1; after issue with i_ready=1, pend[1]=1.
- Follow with 0x00108133 (add x2,x1,x1) → o_valid=0 while pend[1]. Pulse i_wb_valid with i_wb_rd=1 → o_valid=1 that same cycle. On issue pend[1]=0 and pend[2]=1.
- Immediates: 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, type 3, rd_we=0. 0x800002B7 (lui x5) → imm=0x80000000, type 4. With XLEN=64, lui → 0xFFFFFFFF80000000.
- 0x00000000 → o_illegal=1, rd_we=0, imm=0, issues immediately; pend unchanged.
- Backpressure: held addi with i_ready=0 for 5 cycles → o_ready=0 and outputs constant. Then i_ready=1 together with i_valid=1 → issue and accept occur in the same cycle.
- Stalled add plus i_flush → o_valid=0 next cycle, state EMPTY, pend[1] still set. Separately, assert i_rst mid-stall → pend=0 and o_valid=0 after the edge.
